fetch: RTL
==========

Name: fetch

Overview:
Instruction-fetch stage directly upstream of decode. Owns the architectural PC and issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake. Buffers returned words with their PC in a small FIFO and presents {pc, instr} to decode with a valid/stall handshake. Consumes decode's pc_sel/pc_bj as a redirect that flushes all in-flight and buffered fetches.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
BUF_DEPTH, 2, FIFO entries of {pc, instr}; power of two, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  decode cannot accept the current if_pc/if_instr
pc_sel  in  1  redirect request from decode, single-cycle pulse
pc_bj  in  32 (data_t)  redirect target
imem_req  out  1  memory read request
imem_addr  out  32 (data_t)  request address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32 (instr_t)  read data
if_valid  out  1  if_pc/if_instr hold a real instruction
if_pc  out  32 (data_t)  PC of presented instruction
if_instr  out  32 (instr_t)  presented instruction; NOP when invalid

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=BOOT_ADDR; FIFO empty; state RUN.
  - imem_req=0, imem_addr=BOOT_ADDR, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
- Memory handshake:
  - imem_req may assert when (FIFO count + outstanding) < BUF_DEPTH and state is RUN.
  - Once asserted, imem_req and imem_addr hold until the imem_gnt cycle.
  - On gnt: outstanding=1, the granted address is latched as resp_pc, fetch_pc += 4.
  - Response comes on imem_rvalid at least 1 cycle after gnt. At most one outstanding request.
  - A new req may assert in the same cycle as rvalid.
- FSM:
  - RUN: normal operation.
  - WAIT: outstanding=1, no req.
  - FLUSH: outstanding response is discarded.
  - RUN->WAIT on gnt. WAIT->RUN on rvalid.
  - WAIT->FLUSH on pc_sel without same-cycle rvalid. FLUSH->RUN on rvalid, and that data is dropped.
- FIFO write: on rvalid in WAIT, push {resp_pc, imem_rdata}.
- FIFO read: if_valid = !empty. Head drives if_pc/if_instr. Pop when if_valid && !stall.
- Push and pop in the same cycle are both performed. A push into an empty FIFO becomes visible the next cycle (rvalid -> if_valid latency 1).
- Redirect (pc_sel=1) has priority over everything else in that cycle:
  - FIFO cleared; fetch_pc = {pc_bj[31:2], 2'b00}.
  - Any same-cycle push or pop is cancelled; if_valid=0 next cycle.
  - If a request is un-granted, imem_req drops the next cycle and re-issues with the new address.
  - If gnt coincides with pc_sel: the request is counted outstanding and enters FLUSH.
- stall high: outputs held stable and fetching continues until the FIFO is full. Outputs never change while if_valid && stall, except on redirect.
- Full FIFO plus outstanding response cannot occur because the issue rule prevents it.
- PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_flushed (32), both cleared on reset and wrapping at 2^32.
  - perf_fetched increments on each FIFO pop.
  - perf_flushed increments by (FIFO count + discarded responses) on each redirect.
- Undefined: ports and counters are absent, with no other change.

Decomposition:
- Shared defines package provides data_t, instr_t, NOP_INSTR (32'h0000_0013) and a fetch_state_t enum {RUN, WAIT, FLUSH}.
- Package also holds the typedef fetch_entry_t struct {data_t pc; instr_t instr}.
- One sub-module: fetch_fifo (parameter DEPTH; push/pop/clear, count, head; async reset). Used by fetch.

Test Plan:
- Reset release, memory gnt same cycle, rvalid 1 cycle later, stall=0 -> addresses 0,4,8,…; if_pc sequence 0,4,8 with matching instrs; first if_valid 1 cycle after first rvalid.
- stall=1 for 10 cycles -> exactly BUF_DEPTH=2 words buffered; imem_req=0 after that; if_pc/if_instr constant; release -> in-order drain with no loss or duplication.
- pc_sel with pc_bj=32'h0000_0103 while a response is outstanding -> FSM goes to FLUSH; the stale rvalid data never appears on if_instr; next imem_addr = 32'h0000_0100.
- Redirect in the same cycle as rvalid and pop -> FIFO empty next cycle, if_valid=0; next fetch from pc_bj.
- imem_gnt withheld 5 cycles -> imem_req/imem_addr stable throughout; BOOT_ADDR=32'hFFFF_FFF8 -> fetch sequence wraps FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n=0 mid-WAIT -> outputs return to reset values immediately; the pending rvalid after reset is ignored (FSM in RUN, outstanding=0).

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] instr_t;

  // addi x0, x0, 0 -- presented to decode whenever no real instruction is available
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    data_t  pc;
    instr_t instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic data_t align_word(input data_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus (req/gnt/rvalid).
interface fetch_if;
  import fetch_pkg::*;

  logic   req;
  data_t  addr;
  logic   gnt;
  logic   rvalid;
  instr_t rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO of {pc, instr} entries with synchronous
// clear; clear wins over any same-cycle push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop_i & (count_q != '0);
  assign do_push_s = push_i & ((count_q < CW'(DEPTH)) | do_pop_s);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; written only by an accepted, non-cleared push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push_s && !clear_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch.sv
// fetch: instruction-fetch stage. Owns the PC, issues one-outstanding reads
// over fetch_if, buffers responses in fetch_fifo and presents {pc, instr} to
// decode. A pc_sel redirect flushes buffered and in-flight fetches.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch
  import fetch_pkg::*;
#(
  parameter data_t       BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    stall,
  input  logic    pc_sel,
  input  data_t   pc_bj,
  fetch_if.master imem,
  output logic    if_valid,
  output data_t   if_pc,
  output instr_t  if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_q;
  data_t         fetch_pc_q;
  data_t         resp_pc_q;
  logic          req_q;
  logic          req_d;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_d;
  fetch_entry_t  head_s;
  fetch_entry_t  wentry_s;
  logic          gnt_s;
  logic          push_s;
  logic          pop_s;
  logic          run_next_s;

  assign gnt_s    = req_q & imem.gnt;
  assign if_valid = (count_s != '0);
  // Redirect cancels any same-cycle push or pop
  assign pop_s    = if_valid & ~stall & ~pc_sel;
  assign push_s   = (state_q == WAIT) & imem.rvalid & ~pc_sel;
  assign count_d  = pc_sel ? '0 : (count_s + CW'(push_s) - CW'(pop_s));
  // Will the FSM be in RUN (nothing outstanding) next cycle?
  assign run_next_s = (state_q == RUN) ? ~gnt_s : imem.rvalid;

  assign wentry_s.pc    = resp_pc_q;
  assign wentry_s.instr = imem.rdata;

  // Request issue: hold until granted, drop on redirect, otherwise issue
  // only when buffered plus outstanding words leave room in the FIFO
  always_comb begin
    req_d = 1'b0;
    if (pc_sel) begin
      req_d = 1'b0;
    end else if (req_q && !gnt_s) begin
      req_d = 1'b1;
    end else begin
      req_d = run_next_s && (count_d < CW'(BUF_DEPTH));
    end
  end

  // Fetch FSM with PC, response-PC and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= '0;
      req_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (gnt_s) begin
            state_q   <= pc_sel ? FLUSH : WAIT;
            resp_pc_q <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (imem.rvalid)  state_q <= RUN;
          else if (pc_sel)  state_q <= FLUSH;
        end
        FLUSH: begin
          if (imem.rvalid)  state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      if (pc_sel)      fetch_pc_q <= align_word(pc_bj);
      else if (gnt_s)  fetch_pc_q <= fetch_pc_q + 32'd4;
      req_q <= req_d;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (pc_sel),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wentry_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

  assign imem.req  = req_q;
  assign imem.addr = fetch_pc_q;

  // Decode-facing outputs: FIFO head when valid, zero PC and NOP otherwise
  always_comb begin
    if_pc    = '0;
    if_instr = NOP_INSTR;
    if (if_valid) begin
      if_pc    = head_s.pc;
      if_instr = head_s.instr;
    end else begin
      if_pc    = '0;
      if_instr = NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  // Count delivered instructions and instructions thrown away by redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (pop_s) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (pc_sel) perf_flushed_q <= perf_flushed_q + 32'(count_s)
                                  + (((state_q == WAIT) || gnt_s) ? 32'd1 : 32'd0);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
